// File: rtl/add_seq_256.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : add_seq_256
// Brief    : Multi-limb add/subtract sequenced through one shared external adder.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module add_seq_256 #(
   parameter int LIMB_W = 64,
   parameter int N_LIMB = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [LIMB_W*N_LIMB-1:0]   op_a,
   input  logic [LIMB_W*N_LIMB-1:0]   op_b,
   input  logic                       op_sub,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [LIMB_W*N_LIMB-1:0]   result,
   output logic                       cout,
   output logic [LIMB_W-1:0]          add_a,
   output logic [LIMB_W-1:0]          add_b,
   output logic                       add_in,
   input  logic [LIMB_W-1:0]          add_sum,
   input  logic                       add_coin
);

   localparam int OP_W  = LIMB_W * N_LIMB;
   localparam int IDX_W = (N_LIMB > 1) ? $clog2(N_LIMB) : 1;
   localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(N_LIMB - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [OP_W-1:0]    r_a;
   logic [OP_W-1:0]    r_b;
   logic               r_sub;
   logic               r_carry;
   logic [IDX_W-1:0]   r_idx;
   logic [OP_W-1:0]    r_result;
   logic               r_cout;
   logic               w_last;

   assign w_last = (r_idx == C_LAST_IDX);
   assign result = r_result;
   assign cout   = r_cout;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      add_a     = '0;
      add_b     = '0;
      add_in    = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_next = S_RUN;
            end
         end
         S_RUN: begin
            // Subtraction is a + ~b + 1; the +1 enters through the preloaded carry.
            add_a  = r_a[r_idx*LIMB_W +: LIMB_W];
            add_b  = r_b[r_idx*LIMB_W +: LIMB_W] ^ {LIMB_W{r_sub}};
            add_in = r_carry;
            if (w_last) begin
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_next = S_IDLE;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a      <= '0;
         r_b      <= '0;
         r_sub    <= 1'b0;
         r_carry  <= 1'b0;
         r_idx    <= '0;
         r_result <= '0;
         r_cout   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a     <= op_a;
                  r_b     <= op_b;
                  r_sub   <= op_sub;
                  r_carry <= op_sub;
                  r_idx   <= '0;
               end
            end
            S_RUN: begin
               r_result[r_idx*LIMB_W +: LIMB_W] <= add_sum;
               r_carry <= add_coin;
               r_idx   <= r_idx + 1'b1;
               if (w_last) begin
                  r_cout <= add_coin;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_add_seq_256.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_add_seq_256
// Brief    : Self-checking bench for add_seq_256 with a behavioural adder and model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_add_seq_256;

   localparam int LW = 64;
   localparam int NL = 4;
   localparam int OW = LW * NL;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [OW-1:0] op_a = '0;
   logic [OW-1:0] op_b = '0;
   logic          op_sub = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [OW-1:0] result;
   logic          cout;
   logic [LW-1:0] add_a;
   logic [LW-1:0] add_b;
   logic          add_in;
   logic [LW-1:0] add_sum;
   logic          add_coin;

   int n_chk = 0;
   int n_err = 0;

   add_seq_256 #(.LIMB_W(LW), .N_LIMB(NL)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .op_a(op_a), .op_b(op_b), .op_sub(op_sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .cout(cout),
      .add_a(add_a), .add_b(add_b), .add_in(add_in),
      .add_sum(add_sum), .add_coin(add_coin)
   );

   // Stand-in for the external 64-bit adder.
   assign {add_coin, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{LW{1'b0}}, add_in};

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [OW:0] act, input logic [OW:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [OW:0] ref_op(input logic [OW-1:0] a, input logic [OW-1:0] b,
                                          input logic s);
      if (s) return {(a >= b), a - b};
      else   return {1'b0, a} + {1'b0, b};
   endfunction

   // Transaction-level model: 0 idle, 1 computing, 2 holding a result.
   int            m_phase = 0;
   int            m_cnt   = 0;
   logic [OW-1:0] m_a     = '0;
   logic [OW:0]   m_exp   = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase = 0;
         m_cnt   = 0;
      end else begin
         case (m_phase)
            0: if (in_valid) begin
                  m_a     = op_a;
                  m_exp   = ref_op(op_a, op_b, op_sub);
                  m_phase = 1;
                  m_cnt   = 0;
               end
            1: begin
                  m_cnt++;
                  if (m_cnt == NL) m_phase = 2;
               end
            default: if (out_ready) m_phase = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("in_ready", in_ready, m_phase == 0);
         chk("out_valid", out_valid, m_phase == 2);
         if (m_phase == 2) begin
            chk("result", result, m_exp[OW-1:0]);
            chk("cout", cout, m_exp[OW]);
         end
         if (m_phase == 1) chk("add_a_limb", add_a, m_a[m_cnt*LW +: LW]);
         else              chk("adder_idle", {add_a, add_b, add_in}, '0);
      end
   end

   task automatic send(input logic [OW-1:0] a, input logic [OW-1:0] b, input logic s);
      int t = 0;
      while (!in_ready && t < 200) begin
         @(posedge clk); #1; t++;
      end
      chk("send_timeout", t >= 200, 0);
      op_a = a; op_b = b; op_sub = s; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      // Scramble operands after acceptance; they must be ignored.
      op_a = {8{$urandom}}; op_b = {8{$urandom}}; op_sub = 1'($urandom);
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge clk); #1; lat++;
      end
   endtask

   task automatic directed(input string name, input logic [OW-1:0] a, input logic [OW-1:0] b,
                           input logic s, input logic [OW-1:0] er, input logic ec);
      int lat;
      out_ready = 1'b0;
      send(a, b, s);
      wait_done(lat);
      chk({name, "_latency"}, lat, NL);
      chk({name, "_result"}, result, er);
      chk({name, "_cout"}, cout, ec);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({name, "_ready_after"}, in_ready, 1'b1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [OW-1:0] ones;
      logic [OW-1:0] hold_r;
      logic          hold_c;
      int            lat;
      ones = '1;
      rst  = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_result", result, '0);
      chk("rst_cout", cout, 1'b0);

      directed("add_limb_carry", {192'd0, 64'hFFFF_FFFF_FFFF_FFFF}, 256'd1, 1'b0,
               {128'd0, 64'd1, 64'd0}, 1'b0);
      directed("full_chain", ones, 256'd1, 1'b0, 256'd0, 1'b1);
      directed("sub_borrow", 256'd5, 256'd7, 1'b1, ones - 256'd1, 1'b0);
      directed("sub_ok", 256'd7, 256'd5, 1'b1, 256'd2, 1'b1);

      // Hold the result under backpressure.
      out_ready = 1'b0;
      send(256'h1234_5678, 256'h1111, 1'b0);
      wait_done(lat);
      hold_r = result;
      hold_c = cout;
      chk("bp_value", result, 256'h1234_6789);
      repeat (10) begin
         @(posedge clk); #1;
         chk("bp_stable_result", result, hold_r);
         chk("bp_stable_cout", cout, hold_c);
         chk("bp_in_ready", in_ready, 1'b0);
         chk("bp_out_valid", out_valid, 1'b1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp_release_out_valid", out_valid, 1'b0);
      chk("bp_release_in_ready", in_ready, 1'b1);

      // Abort mid-operation after two limbs.
      send(ones, ones, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("abort_result", result, '0);
      chk("abort_cout", cout, 1'b0);
      chk("abort_out_valid", out_valid, 1'b0);
      chk("abort_adder", {add_a, add_b, add_in}, '0);
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_in_ready", in_ready, 1'b1);
      @(posedge clk); #1;
      chk("abort_no_output", out_valid, 1'b0);
      directed("post_abort", 256'd3, 256'd4, 1'b0, 256'd7, 1'b0);

      // Back-to-back random traffic with random consumer stalls.
      for (int k = 0; k < 12; k++) begin
         int t;
         send({8{$urandom}}, {8{$urandom}}, 1'($urandom));
         t = 0;
         while (!in_ready && t < 200) begin
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1; t++;
         end
         chk("rand_timeout", t >= 200, 0);
      end
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/add_seq_256.md
ADD_SEQ_256 -- requirements
Module: add_seq_256

Interface
REQ-001 Parameter LIMB_W, default 64, width of the shared adder limb (matches add_64).
REQ-002 Parameter N_LIMB, default 4, number of limbs per operand; total operand width OP_W = LIMB_W*N_LIMB.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  request carries a valid operand pair.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 op_a  input  OP_W  first operand.
REQ-008 op_b  input  OP_W  second operand.
REQ-009 op_sub  input  1  0 = a+b, 1 = a-b.
REQ-010 out_valid  output  1  result and carry are valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 result  output  OP_W  sum/difference modulo 2^OP_W.
REQ-013 cout  output  1  final carry-out (for subtract: 1 = no borrow, a>=b).
REQ-014 add_a  output  LIMB_W  limb A to external add_64 instance.
REQ-015 add_b  output  LIMB_W  limb B (already inverted for subtract) to adder.
REQ-016 add_in  output  1  carry-in to adder.
REQ-017 add_sum  input  LIMB_W  combinational sum from adder, same cycle.
REQ-018 add_coin  input  1  combinational carry-out from adder, same cycle.

Function
REQ-019 FSM states: IDLE, RUN, DONE; one-hot or binary encoding is implementation choice.
REQ-020 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-021 IDLE and in_valid=1: capture op_a, op_b, op_sub into internal registers, clear limb index to 0, load carry register with op_sub, go to RUN.
REQ-022 Operand inputs SHALL be ignored outside the accepting edge; changes during RUN/DONE have no effect.
REQ-023 In RUN, add_a = captured A limb[idx], add_b = captured B limb[idx] XOR {LIMB_W{sub}}, add_in = carry register.
REQ-024 Each RUN edge: result limb[idx] <= add_sum, carry register <= add_coin, idx <= idx+1.
REQ-025 RUN edge with idx = N_LIMB-1: cout <= add_coin, go to DONE; exactly N_LIMB RUN cycles.
REQ-026 Latency: out_valid asserted N_LIMB cycles after the accepting edge (4 for default).
REQ-027 DONE: result and cout held stable while out_valid=1 and out_ready=0.
REQ-028 DONE and out_ready=1: go to IDLE; in_ready rises the following cycle (no same-cycle re-accept; throughput one request per N_LIMB+2 cycles minimum).
REQ-029 Outside RUN, add_a, add_b, add_in SHALL be driven 0.
REQ-030 result limbs not yet written in the current operation SHALL keep prior values; only DONE state makes result valid.
REQ-031 Arithmetic wraps modulo 2^OP_W; no overflow flag.

Reset
REQ-032 rst=1 at any time, including mid-RUN, SHALL asynchronously force IDLE, idx=0, carry=0, result=0, cout=0, captured operands=0; any in-flight operation is discarded.
REQ-033 After rst deasserts, in_ready=1 and out_valid=0 from the first clock; no operation output is produced for an aborted request.

Verification
REQ-034 Add: a=2^64-1, b=1, sub=0 -> out_valid 4 cycles after accept, result=2^64 (limb1=1, others 0), cout=0.
REQ-035 Full carry chain: a=2^256-1, b=1, sub=0 -> result=0, cout=1.
REQ-036 Subtract: a=5, b=7, sub=1 -> result=2^256-2, cout=0; a=7, b=5 -> result=2, cout=1.
REQ-037 Backpressure: out_ready=0 for 10 cycles in DONE -> result/cout stable, in_ready=0 throughout; out_ready=1 -> IDLE next edge, in_ready=1 cycle after.
REQ-038 Reset mid-RUN after 2 limbs -> all outputs 0, in_ready=1 after release; next request a=3,b=4 yields result=7 with no corruption.
REQ-039 Random back-to-back requests with random out_ready stalls -> every result/cout matches a 257-bit reference model, adder ports 0 outside RUN.
